rom_fetch_arbiter: RTL

- Sequencing controller for the single-port instruction ROM (32-bit x 1024 words, 10-bit word address, combinational read).
- Owns the ROM address mux and shares it between the instruction-fetch stream (internal PC) and a data-read port used by loads of ROM-resident constants.
- Delivers registered instructions to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and a debug halt.

---
 rtl/rom_fetch_pkg.sv | 27 ++
 rtl/rom_fetch_arbiter_port_arb.sv | 42 ++++
 rtl/rom_fetch_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the instruction-ROM fetch/data arbiter.
// Holds the controller state encoding and small address helpers.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int INST_W    = 32;
    localparam int PC_W      = 32;
    localparam int ROM_WORDS = 1024;
    localparam int BURST_W   = 4;

    // Self-branch word used to mark the end of a program image.
    localparam logic [INST_W-1:0] HALT_SELF_LOOP = 32'h1000_ffff;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_port_arb.sv
// ROM port arbiter: data reads win until the fetch stream has waited
// DATA_BURST_MAX consecutive data grants, then fetch gets one slot.
module rom_port_arb
    import rom_fetch_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_want,
    input  logic data_want,
    input  logic halt_req,
    output logic fetch_gnt,
    output logic data_gnt
);

    logic [BURST_W-1:0] burst_r;
    logic               fetch_live_s;
    logic               burst_full_s;

    // A pending halt withdraws the fetch stream from arbitration.
    always_comb begin
        fetch_live_s = fetch_want && !halt_req;
        burst_full_s = (burst_r == BURST_W'(DATA_BURST_MAX));
        data_gnt     = data_want && !(fetch_live_s && burst_full_s);
        fetch_gnt    = fetch_live_s && !data_gnt;
    end

    // Count data grants that starved a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (!fetch_live_s || fetch_gnt) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (data_gnt) begin
            burst_r <= burst_r + BURST_W'(1);
        end else begin
            burst_r <= burst_r;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Sequencing controller for the single-port instruction ROM: shares the ROM
// between the PC-driven fetch stream and a constant-load data port.
module rom_fetch_arbiter
    import rom_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          DATA_BURST_MAX = 4,
    parameter int          ADDR_W         = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              dread_req,
    input  logic [31:0]       dread_addr,
    output logic              dread_gnt,
    output logic              dread_valid,
    output logic [31:0]       dread_data,
    input  logic              halt_req,
    output logic              halted,
    output logic              misalign_err
);

    fetch_state_t      state_r;
    logic              halted_r;
    logic [PC_W-1:0]   pc_r;
    logic              inst_valid_r;
    logic [INST_W-1:0] inst_r;
    logic [PC_W-1:0]   inst_pc_r;
    logic              dread_valid_r;
    logic [INST_W-1:0] dread_data_r;
    logic              misalign_r;

    logic [PC_W-1:0]   fetch_addr_s;
    logic              fetch_want_s;
    logic              data_want_s;
    logic              fetch_gnt_s;
    logic              data_gnt_s;
    logic [ADDR_W-1:0] rom_addr_s;
    logic              unused_s;

    // ROM image aliases above the word-address range.
    assign unused_s = ^dread_addr[PC_W-1:ADDR_W+2];

    // Fetch target and request qualification.
    always_comb begin
        if (redirect_valid) begin
            fetch_addr_s = word_align(redirect_pc);
        end else begin
            fetch_addr_s = pc_r;
        end
        fetch_want_s = (state_r == ST_RUN) && (!inst_valid_r || inst_ready);
        data_want_s  = dread_req && (state_r != ST_BOOT);
    end

    rom_port_arb #(
        .DATA_BURST_MAX (DATA_BURST_MAX)
    ) u_port_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_want (fetch_want_s),
        .data_want  (data_want_s),
        .halt_req   (halt_req),
        .fetch_gnt  (fetch_gnt_s),
        .data_gnt   (data_gnt_s)
    );

    // ROM address mux; idles on the current pc index.
    always_comb begin
        if (data_gnt_s) begin
            rom_addr_s = dread_addr[ADDR_W+1:2];
        end else if (fetch_gnt_s) begin
            rom_addr_s = fetch_addr_s[ADDR_W+1:2];
        end else begin
            rom_addr_s = pc_r[ADDR_W+1:2];
        end
    end

    // Controller FSM with registered halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_BOOT;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_BOOT;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Program counter; a redirect without a fetch slot is parked here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (fetch_gnt_s) begin
            pc_r <= fetch_addr_s + 32'd4;
        end else if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction output register toward decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
        end else if (fetch_gnt_s) begin
            inst_valid_r <= 1'b1;
            inst_r       <= rom_data;
            inst_pc_r    <= fetch_addr_s;
        end else if (redirect_valid || (inst_valid_r && inst_ready)) begin
            inst_valid_r <= 1'b0;
        end else begin
            inst_valid_r <= inst_valid_r;
        end
    end

    // Data-read return: one-cycle valid pulse after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dread_valid_r <= 1'b0;
            dread_data_r  <= 32'd0;
        end else if (data_gnt_s) begin
            dread_valid_r <= 1'b1;
            dread_data_r  <= rom_data;
        end else begin
            dread_valid_r <= 1'b0;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if ((redirect_valid && is_misaligned(redirect_pc)) ||
                     (data_gnt_s && is_misaligned(dread_addr))) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign rom_addr     = rom_addr_s;
    assign dread_gnt    = data_gnt_s;
    assign inst_valid   = inst_valid_r;
    assign inst         = inst_r;
    assign inst_pc      = inst_pc_r;
    assign dread_valid  = dread_valid_r;
    assign dread_data   = dread_data_r;
    assign halted       = halted_r;
    assign misalign_err = misalign_r;

endmodule
